// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: sequencer for one arbiter-PUF race path.
// Per accepted request it latches a challenge, runs N_EVAL
// reset/settle/launch/capture rounds on the arbiter, majority-votes the
// captured bits into one response bit, and flags stability and timeout.
//
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   start            request, sampled only while idle
//   challenge        challenge word, latched on an accepted start
//   busy             high from the cycle after acceptance until idle again
//   puf_challenge    registered challenge to the delay-chain selects
//   arb_rst          arbiter reset (active-high)
//   launch           race launch into both chains
//   arb_done         arbiter done (asynchronous to clk)
//   arb_result       arbiter winner, 1 = path a (asynchronous to clk)
//   resp_valid       one-cycle pulse marking a completed request
//   resp_bit         majority-voted response
//   resp_stable      all evaluations agreed
//   ones_cnt         number of 1 results in the last request
//   timeout_err      last request aborted on timeout / arbiter not cleared
module puf_eval_ctrl #(
  parameter int CHAL_W      = 64,
  parameter int N_EVAL      = 7,
  parameter int RST_CYC     = 2,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 16,
  parameter int CW          = $clog2(N_EVAL + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CHAL_W-1:0] challenge,
  output logic              busy,
  output logic [CHAL_W-1:0] puf_challenge,
  output logic              arb_rst,
  output logic              launch,
  input  logic              arb_done,
  input  logic              arb_result,
  output logic              resp_valid,
  output logic              resp_bit,
  output logic              resp_stable,
  output logic [CW-1:0]     ones_cnt,
  output logic              timeout_err
);

  // One shared counter serves RST, SETTLE and the WAIT timeout.
  localparam int MAX_A = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
  localparam int MAX_C = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
  localparam int CNT_W = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_SETTLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state;
  logic [1:0]      done_sync;
  logic [1:0]      result_sync;
  logic            done_s;
  logic            result_s;
  logic [CNT_W-1:0] cnt;
  logic [CW-1:0]   eval_cnt;
  logic [CW-1:0]   acc;
  logic [CW-1:0]   acc_inc;
  logic [CW-1:0]   eval_inc;

  assign done_s   = done_sync[1];
  assign result_s = result_sync[1];

  always_comb begin
    acc_inc  = acc + CW'(result_s);
    eval_inc = eval_cnt + CW'(1);
  end

  // Two-flop synchronizers; nothing downstream looks at the raw inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_sync   <= '0;
      result_sync <= '0;
    end else begin
      done_sync   <= {done_sync[0], arb_done};
      result_sync <= {result_sync[0], arb_result};
    end
  end

  // Outputs are registered and updated on state transitions so each
  // output reflects the state it belongs to in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      eval_cnt      <= '0;
      acc           <= '0;
      busy          <= 1'b0;
      puf_challenge <= '0;
      arb_rst       <= 1'b1;
      launch        <= 1'b0;
      resp_valid    <= 1'b0;
      resp_bit      <= 1'b0;
      resp_stable   <= 1'b0;
      ones_cnt      <= '0;
      timeout_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          arb_rst <= 1'b1;
          launch  <= 1'b0;
          if (start) begin
            puf_challenge <= challenge;
            eval_cnt      <= '0;
            acc           <= '0;
            timeout_err   <= 1'b0;
            cnt           <= '0;
            busy          <= 1'b1;
            state         <= S_RST;
          end
        end

        S_RST: begin
          if (cnt == CNT_W'(RST_CYC - 1)) begin
            cnt     <= '0;
            arb_rst <= 1'b0;
            state   <= S_SETTLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_SETTLE: begin
          if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
            cnt    <= '0;
            launch <= 1'b1;
            state  <= S_LAUNCH;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_LAUNCH: begin
          cnt <= '0;
          // A done already present here means the arbiter never cleared;
          // abort the request the same way as a timeout.
          if (done_s) begin
            launch      <= 1'b0;
            arb_rst     <= 1'b1;
            timeout_err <= 1'b1;
            resp_valid  <= 1'b1;
            resp_bit    <= 1'b0;
            resp_stable <= 1'b0;
            ones_cnt    <= acc;
            state       <= S_DONE;
          end else begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          // Timeout fires when the incremented count reaches TIMEOUT_CYC-1,
          // so launch (LAUNCH + WAIT) is high for TIMEOUT_CYC cycles.
          if (done_s) begin
            launch   <= 1'b0;
            arb_rst  <= 1'b1;
            acc      <= acc_inc;
            eval_cnt <= eval_inc;
            cnt      <= '0;
            if (eval_inc == CW'(N_EVAL)) begin
              resp_valid  <= 1'b1;
              ones_cnt    <= acc_inc;
              resp_bit    <= (acc_inc > CW'(N_EVAL / 2));
              resp_stable <= (acc_inc == '0) || (acc_inc == CW'(N_EVAL));
              state       <= S_DONE;
            end else begin
              state <= S_RST;
            end
          end else if (cnt == CNT_W'(TIMEOUT_CYC - 2)) begin
            launch      <= 1'b0;
            arb_rst     <= 1'b1;
            timeout_err <= 1'b1;
            resp_valid  <= 1'b1;
            resp_bit    <= 1'b0;
            resp_stable <= 1'b0;
            ones_cnt    <= acc;
            state       <= S_DONE;
          end
        end

        S_DONE: begin
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          arb_rst    <= 1'b1;
          launch     <= 1'b0;
          state      <= S_IDLE;
        end

        default: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          arb_rst <= 1'b1;
          launch  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb_puf_eval_ctrl: directed bench for puf_eval_ctrl with a behavioural
// arbiter model, an expected-response queue and a resp_valid monitor.
module tb_puf_eval_ctrl;

  localparam int RST_CYC     = 2;
  localparam int SETTLE_CYC  = 4;
  localparam int TIMEOUT_CYC = 16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] challenge;
  logic        busy;
  logic [63:0] puf_challenge;
  logic        arb_rst;
  logic        launch;
  logic        arb_done;
  logic        arb_result;
  logic        resp_valid;
  logic        resp_bit;
  logic        resp_stable;
  logic [2:0]  ones_cnt;
  logic        timeout_err;

  puf_eval_ctrl #(
    .CHAL_W(64), .N_EVAL(7), .RST_CYC(RST_CYC),
    .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
    .busy(busy), .puf_challenge(puf_challenge), .arb_rst(arb_rst),
    .launch(launch), .arb_done(arb_done), .arb_result(arb_result),
    .resp_valid(resp_valid), .resp_bit(resp_bit), .resp_stable(resp_stable),
    .ones_cnt(ones_cnt), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] chal;
    logic        rbit;
    logic        stable;
    logic [2:0]  ones;
    logic        terr;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int n_checks = 0;
  int n_fail   = 0;
  int rv_count = 0;
  int n_launch = 0;
  int last_l   = 0;
  int l_run    = 0;
  int rst_run  = 0;
  int set_run  = 0;

  // Arbiter model controls
  logic res_tab[7];
  logic en_tab[7];
  int   round = 0;
  logic stuck = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Arbiter model: done+result 3 cycles after a launch edge, cleared by arb_rst.
  initial begin
    int cd;
    logic cur_res;
    logic launch_q;
    cd = -1; cur_res = 1'b0; launch_q = 1'b0;
    arb_done = 1'b0; arb_result = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stuck) arb_done = 1'b1;
      else if (arb_rst) begin arb_done = 1'b0; cd = -1; end
      if (launch && !launch_q) begin
        if (round < 7 && en_tab[round]) begin cd = 3; cur_res = res_tab[round]; end
        else cd = -1;
        round++;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin arb_done = 1'b1; arb_result = cur_res; end
      end
      launch_q = launch;
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      rv_count++;
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp_valid: got resp_valid=1 expected none queued");
      end else begin
        e = q.pop_front();
        check("puf_challenge", puf_challenge, e.chal);
        check("resp_bit", 64'(resp_bit), 64'(e.rbit));
        check("resp_stable", 64'(resp_stable), 64'(e.stable));
        check("ones_cnt", 64'(ones_cnt), 64'(e.ones));
        check("timeout_err", 64'(timeout_err), 64'(e.terr));
      end
    end
  end

  // Phase-length monitor: RST and SETTLE durations inside a request, launch width.
  always @(negedge clk) begin
    if (!busy) begin
      rst_run = 0;
      set_run = 0;
    end else begin
      if (arb_rst) begin
        rst_run++;
        set_run = 0;
      end else begin
        if (rst_run != 0) check("rst_len", 64'(rst_run), 64'(RST_CYC));
        rst_run = 0;
        if (!launch) set_run++;
        else if (set_run != 0) begin
          check("settle_len", 64'(set_run), 64'(SETTLE_CYC));
          set_run = 0;
        end
      end
    end
    if (launch) begin
      if (l_run == 0) n_launch++;
      l_run++;
    end else if (l_run != 0) begin
      last_l = l_run;
      l_run = 0;
    end
  end

  task automatic set_tabs(input logic [6:0] res, input logic [6:0] en);
    for (int unsigned i = 0; i < 7; i++) begin
      res_tab[i] = res[6-i];
      en_tab[i]  = en[6-i];
    end
  endtask

  task automatic run_req(input string tag, input logic [63:0] ch, input logic rbit,
                         input logic stable, input logic [2:0] ones, input logic terr,
                         input int exp_rounds);
    exp_t x;
    int rv0;
    int i;
    x.chal = ch; x.rbit = rbit; x.stable = stable; x.ones = ones; x.terr = terr;
    q.push_back(x);
    round = 0;
    rv0 = rv_count;
    @(negedge clk);
    start = 1'b1;
    challenge = ch;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_after_accept"}, 64'(busy), 64'd1);
    i = 0;
    while (busy && i < 3000) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_finished_in_bound"}, 64'(busy), 64'd0);
    check({tag, "_one_resp_valid"}, 64'(rv_count - rv0), 64'd1);
    check({tag, "_rounds"}, 64'(round), 64'(exp_rounds));
  endtask

  initial begin
    int i;
    int rv0;
    rst_n = 1'b0; start = 1'b0; challenge = '0;
    set_tabs(7'b1111111, 7'b1111111);
    #23;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_arb_rst", 64'(arb_rst), 64'd1);
    check("rst_launch", 64'(launch), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_bit", 64'(resp_bit), 64'd0);
    check("rst_resp_stable", 64'(resp_stable), 64'd0);
    check("rst_ones_cnt", 64'(ones_cnt), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);
    check("rst_puf_challenge", puf_challenge, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // All rounds return 1: unanimous
    set_tabs(7'b1111111, 7'b1111111);
    run_req("all_ones", 64'hA5A5_0000_FFFF_1234, 1'b1, 1'b1, 3'd7, 1'b0, 7);
    check("idle_arb_rst_high", 64'(arb_rst), 64'd1);

    // Mixed results
    set_tabs(7'b1011001, 7'b1111111);
    run_req("mix4", 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 3'd4, 1'b0, 7);
    set_tabs(7'b0010100, 7'b1111111);
    run_req("mix2", 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0, 3'd2, 1'b0, 7);

    // Never done: timeout on round 1
    set_tabs(7'b1111111, 7'b0000000);
    run_req("never_done", 64'h1111_2222_3333_4444, 1'b0, 1'b0, 3'd0, 1'b1, 1);
    check("timeout_launch_len", 64'(last_l), 64'(TIMEOUT_CYC));
    check("timeout_arb_rst_high", 64'(arb_rst), 64'd1);

    // Round 4 fails: partial count kept
    set_tabs(7'b1111111, 7'b1110111);
    run_req("round4_fail", 64'h5555_AAAA_5555_AAAA, 1'b0, 1'b0, 3'd3, 1'b1, 4);
    check("terr_holds_in_idle", 64'(timeout_err), 64'd1);
    set_tabs(7'b1111111, 7'b1111111);
    run_req("after_fail", 64'h0F0F_0F0F_F0F0_F0F0, 1'b1, 1'b1, 3'd7, 1'b0, 7);

    // start pulsed during WAIT is ignored
    set_tabs(7'b1011001, 7'b1111111);
    fork
      run_req("start_in_wait", 64'hCAFE_F00D_1234_5678, 1'b1, 1'b0, 3'd4, 1'b0, 7);
      begin
        i = 0;
        @(negedge clk);
        while (!launch && i < 200) begin @(negedge clk); i++; end
        check("saw_launch", 64'(launch), 64'd1);
        @(negedge clk);
        start = 1'b1;
        challenge = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
      end
    join
    repeat (40) @(negedge clk);
    check("no_queued_request", 64'(busy), 64'd0);

    // Asynchronous reset during SETTLE of round 2
    set_tabs(7'b1111111, 7'b1111111);
    round = 0;
    rv0 = rv_count;
    @(negedge clk);
    start = 1'b1;
    challenge = 64'h7777_8888_9999_AAAA;
    @(negedge clk);
    start = 1'b0;
    i = 0;
    while (!launch && i < 200) begin @(negedge clk); i++; end
    while (!arb_rst && i < 200) begin @(negedge clk); i++; end
    while (arb_rst && i < 200) begin @(negedge clk); i++; end
    check("reached_settle2", 64'(busy && !arb_rst && !launch && round == 1), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_arb_rst", 64'(arb_rst), 64'd1);
    check("arst_launch", 64'(launch), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("arst_no_resp_valid", 64'(rv_count - rv0), 64'd0);

    // arb_done stuck high before launch: integrity abort
    stuck = 1'b1;
    repeat (4) @(negedge clk);
    run_req("stuck_done", 64'h0000_0000_0000_BEEF, 1'b0, 1'b0, 3'd0, 1'b1, 1);
    stuck = 1'b0;
    repeat (5) @(negedge clk);

    check("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog");
  end

endmodule
